// File: rtl/crossing_pkg.sv
// Shared constants and the per-stage record carried down the crossing pipeline.
package crossing_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int W_DEF      = 8;
  localparam int STAGES_DEF = 3;
  // Record fields are sized for the widest supported W; bits above W stay zero.
  localparam int DATA_MAX   = 32;

  typedef struct packed {
    logic                valid;
    logic [DATA_MAX-1:0] a;
    logic [DATA_MAX-1:0] b;
    logic                mode;
    logic                sat;
  } stage_t;

endpackage

// File: rtl/crossing_stage.sv
// One registered crossing stage: passes A through, replaces B with B + A
// (wrapping or unsigned-saturating), and accumulates the per-beat saturation flag.
module crossing_stage
  import crossing_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  input  stage_t up_i,
  input  logic   down_ready_i,
  output logic   ready_o,
  output stage_t stage_o
);

  stage_t              stage_d;
  stage_t              stage_q;
  logic [DATA_MAX-1:0] lim_s;
  logic [DATA_MAX:0]   sum_s;
  logic                mode_s;
  logic                sat_event_s;

  // Adder, saturation decision and load/hold of the stage record.
  always_comb begin
    lim_s       = {DATA_MAX{1'b1}} >> (DATA_MAX - W);
    mode_s      = SAT_EN ? up_i.mode : MODE_WRAP;
    sum_s       = {1'b0, up_i.b} + {1'b0, up_i.a};
    sat_event_s = (mode_s == MODE_SAT) && (sum_s > {1'b0, lim_s});
    ready_o     = !stage_q.valid || down_ready_i;
    stage_d     = stage_q;
    if (ready_o) begin
      stage_d.valid = up_i.valid;
      if (up_i.valid) begin
        stage_d.a    = up_i.a;
        stage_d.b    = sat_event_s ? lim_s : (sum_s[DATA_MAX-1:0] & lim_s);
        stage_d.mode = mode_s;
        stage_d.sat  = up_i.sat | sat_event_s;
      end else begin
        stage_d.a = stage_q.a;
      end
    end else begin
      stage_d.valid = stage_q.valid;
    end
  end

  // Stage register; reset discards any beat held here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/crossing_pipe.sv
// Pipelined crossing block: STAGES chained crossing stages with valid/ready
// flow control; out_b = in_b + STAGES*in_a, wrapped or saturated per beat.
module crossing_pipe
  import crossing_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         sat_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         out_sat,
  output logic         busy
);

  stage_t              head_s;
  stage_t              stage_s [STAGES];
  logic [STAGES-1:0]   ready_s;
  logic [STAGES-1:0]   valid_s;

  // Input port presented as the record upstream of stage 0.
  always_comb begin
    head_s       = '0;
    head_s.valid = in_valid;
    head_s.a     = DATA_MAX'(in_a);
    head_s.b     = DATA_MAX'(in_b);
    head_s.mode  = sat_mode;
    head_s.sat   = 1'b0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t up_s;
    logic   down_ready_s;

    if (k == 0) begin : g_head
      assign up_s = head_s;
    end else begin : g_mid
      assign up_s = stage_s[k-1];
    end

    // The ready chain is combinational, so a full pipe can move every cycle.
    if (k == STAGES - 1) begin : g_tail
      assign down_ready_s = out_ready;
    end else begin : g_inner
      assign down_ready_s = ready_s[k+1];
    end

    crossing_stage #(
      .W      (W),
      .SAT_EN (SAT_EN)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .up_i         (up_s),
      .down_ready_i (down_ready_s),
      .ready_o      (ready_s[k]),
      .stage_o      (stage_s[k])
    );

    assign valid_s[k] = stage_s[k].valid;
  end

  assign in_ready  = ready_s[0];
  assign out_valid = stage_s[STAGES-1].valid;
  assign out_a     = stage_s[STAGES-1].a[W-1:0];
  assign out_b     = stage_s[STAGES-1].b[W-1:0];
  assign out_sat   = stage_s[STAGES-1].sat;
  assign busy      = |valid_s;

endmodule

// File: tb/tb_crossing_pipe.sv
// Self-checking bench for crossing_pipe (W=8, STAGES=3): vector table plus
// hand-written latency, backpressure, streaming and reset sequences.
module tb_crossing_pipe;

  localparam int W      = 8;
  localparam int STAGES = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         sat_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic         out_sat;
  logic         busy;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sat;
  } rec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [7:0] exp_b;
    logic       exp_sat;
  } vec_t;

  rec_t sb[$];
  rec_t next_exp;
  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;
  int   popped   = 0;
  int   nb;
  logic in_fire;
  logic out_fire;
  logic ov_s;

  crossing_pipe #(.W(W), .STAGES(STAGES), .SAT_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .sat_mode  (sat_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t model(input logic [7:0] a, input logic [7:0] b, input logic m);
    rec_t       r;
    logic [8:0] s;
    r.a   = a;
    r.b   = b;
    r.sat = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      s = {1'b0, r.b} + {1'b0, a};
      if (m && s > 9'd255) begin
        r.b   = 8'd255;
        r.sat = 1'b1;
      end else begin
        r.b = s[7:0];
      end
    end
    return r;
  endfunction

  // One clock: sample handshakes mid-cycle, score outputs, record accepted input.
  task automatic cycle();
    rec_t e;
    @(negedge clk);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    ov_s     = out_valid;
    if (out_fire) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        popped++;
        check("out_a", 32'(out_a), 32'(e.a));
        check("out_b", 32'(out_b), 32'(e.b));
        check("out_sat", 32'(out_sat), 32'(e.sat));
      end
    end
    if (in_fire) sb.push_back(next_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'd5,   8'd1,   1'b0, 8'd16,  1'b0};
    vecs[1] = '{8'd100, 8'd0,   1'b0, 8'd44,  1'b0};
    vecs[2] = '{8'd100, 8'd0,   1'b1, 8'd255, 1'b1};
    vecs[3] = '{8'd1,   8'd2,   1'b1, 8'd5,   1'b0};
    vecs[4] = '{8'd200, 8'd50,  1'b1, 8'd255, 1'b1};
    vecs[5] = '{8'd0,   8'd255, 1'b1, 8'd255, 1'b0};
    vecs[6] = '{8'd255, 8'd255, 1'b0, 8'd252, 1'b0};
    vecs[7] = '{8'd85,  8'd0,   1'b1, 8'd255, 1'b0};
    vecs[8] = '{8'd86,  8'd0,   1'b1, 8'd255, 1'b1};
    vecs[9] = '{8'd1,   8'd253, 1'b1, 8'd255, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    sat_mode  = 1'b0;
    out_ready = 1'b1;
    next_exp  = '0;
    #12;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_out_b", 32'(out_b), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: single beat appears exactly STAGES cycles after acceptance.
    in_valid = 1'b1;
    in_a     = 8'd5;
    in_b     = 8'd1;
    sat_mode = 1'b0;
    next_exp = model(8'd5, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      in_valid = 1'b0;
      check("lat_out_valid", 32'(ov_s), 32'(i == 3));
    end
    drain();

    // Vector table, back to back.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      sat_mode = vecs[i].mode;
      next_exp = '{vecs[i].a, vecs[i].exp_b, vecs[i].exp_sat};
      cycle();
      check("vec_accept", 32'(in_fire), 32'd1);
    end
    drain();

    // Backpressure: fill, hold, then release.
    popped    = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'd1;
    sat_mode  = 1'b0;
    nb        = 0;
    for (int c = 0; c < 6; c++) begin
      in_b     = 8'(nb);
      next_exp = model(8'd1, 8'(nb), 1'b0);
      cycle();
      if (in_fire) nb++;
    end
    check("bp_accepts", 32'(nb), 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_hold_b", 32'(out_b), 32'd3);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && nb < 5; c++) begin
      in_b     = 8'(nb);
      next_exp = model(8'd1, 8'(nb), 1'b0);
      cycle();
      if (in_fire) nb++;
    end
    drain();
    check("bp_popped", 32'(popped), 32'd5);

    // Streaming: 20 random beats with no bubbles.
    popped    = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 23; i++) begin
      in_valid = (i < 20);
      in_a     = 8'($urandom_range(0, 255));
      in_b     = 8'($urandom_range(0, 255));
      sat_mode = 1'($urandom_range(0, 1));
      next_exp = model(in_a, in_b, sat_mode);
      cycle();
      if (i < 20) check("stream_in_ready", 32'(in_fire), 32'd1);
      check("stream_out_valid", 32'(ov_s), 32'(i >= 3));
    end
    drain();
    check("stream_popped", 32'(popped), 32'd20);

    // Asynchronous reset with beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'd3;
    in_b      = 8'd1;
    sat_mode  = 1'b0;
    next_exp  = model(8'd3, 8'd1, 1'b0);
    cycle();
    in_b     = 8'd2;
    next_exp = model(8'd3, 8'd2, 1'b0);
    cycle();
    in_valid = 1'b0;
    cycle();
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    popped    = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'd2;
    in_b      = 8'd2;
    sat_mode  = 1'b0;
    next_exp  = '{8'd2, 8'd8, 1'b0};
    cycle();
    drain();
    check("post_rst_popped", 32'(popped), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
